block_drawer: RTL and testbench
===============================

// Module: block_drawer
// PURPOSE
//  Downstream of game_logic_top; feeds the VGA adapter's pixel-write port.
//  On each sync pulse it erases the moving block at its old position (prev_x, y).
//  It then paints the block at its new position (x, y), one pixel per clock.
//  busy/done let the top level hold off the next frame until painting finishes.
// PARAMETERS
//  BLOCK_W    20      block width in pixels (1..63)
//  BLOCK_H    4       block height in pixels (1..15)
//  SCREEN_W   160     visible width; pixel columns >= SCREEN_W are clipped
//  SCREEN_H   120     visible height; pixel rows >= SCREEN_H are clipped
//  BG_COLOUR  3'b000  colour written during erase
// PORTS
//  clk        in   1  system clock (CLOCK_50)
//  reset      in   1  asynchronous, active-high reset
//  sync       in   1  start request; single-cycle pulse from game logic
//  x          in   8  new block left column
//  y          in   7  block top row
//  prev_x     in   8  previous block left column
//  colour     in   3  block fill colour
//  vga_x      out  8  pixel column to VGA adapter
//  vga_y      out  7  pixel row to VGA adapter
//  vga_colour out  3  pixel colour
//  plot       out  1  write-enable for the current pixel
//  busy       out  1  high from the cycle after sync is accepted until done
//  done       out  1  one-cycle pulse when the frame is complete
// BEHAVIOUR
//  Reset: state=IDLE; vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0.
//  Reset mid-frame aborts immediately; no further plot pulses are issued.
//  FSM states: IDLE -> ERASE -> DRAW -> DONE -> IDLE.
//  IDLE:
//   - sync=1 latches x, y, prev_x, colour and clears the offset counters.
//   - Next state is ERASE if prev_x != x; if prev_x == x, ERASE is skipped
//     and next state is DRAW.
//  ERASE and DRAW:
//   - One pixel per cycle, row-major: column offset cx counts 0..BLOCK_W-1
//     fastest, then row offset cy counts 0..BLOCK_H-1.
//   - ERASE outputs vga_x = prev_x + cx, vga_colour = BG_COLOUR.
//   - DRAW outputs vga_x = x + cx, vga_colour = latched colour.
//   - Both states output vga_y = y + cy.
//   - Outputs are registered: the first pixel appears the cycle after sync.
//  Clipping:
//   - Sums are computed 9-bit (x) and 8-bit (y).
//   - If a column sum >= SCREEN_W or a row sum >= SCREEN_H: plot=0 for that
//     cycle, and vga_x/vga_y carry the truncated sum.
//   - The cycle is still consumed; there is no wrap-around onto the screen.
//  Transitions:
//   - ERASE -> DRAW after its last pixel; counters reset for DRAW.
//   - DRAW -> DONE after its last pixel.
//   - DONE lasts 1 cycle: done=1, plot=0, busy=0; then return to IDLE.
//  busy: 1 in ERASE and DRAW only; plot is 0 in IDLE and DONE.
//  Latency from sync to done:
//   - 2*BLOCK_W*BLOCK_H + 1 cycles with erase (161 at defaults).
//   - BLOCK_W*BLOCK_H + 1 cycles when erase is skipped (81 at defaults).
//  sync while busy or in DONE: ignored and not queued; latched inputs unchanged.
//  sync in IDLE on the same cycle done deasserts: accepted normally.
//  Input changes while busy: no effect until the next accepted sync.
// TESTING
//  1 reset held, sync pulsed -> all outputs 0, no plot pulses.
//  2 sync with prev_x=10, x=14, y=100, colour=3'b100
//     -> 80 plots of colour 000 at x 10..29, y 100..103;
//     -> then 80 plots of colour 100 at x 14..33; done at cycle 161.
//  3 sync with prev_x=x=50
//     -> no erase plots; 80 draw plots; done at cycle 81.
//  4 x=150, prev_x=150, y=118
//     -> plot=1 only for columns 150..159 and rows 118..119 (20 pixels);
//     -> still 80 draw cycles; done at cycle 81.
//  5 second sync 5 cycles after the first
//     -> ignored; a single done; pixel addresses use the first inputs.
//  6 reset asserted at cycle 40 of DRAW
//     -> plot, busy and done go 0 immediately; next sync starts a fresh frame.

Source files
------------

// File: rtl/block_drawer.sv
// Erases the moving block at its previous column, then paints it at its new
// column, emitting one clipped pixel write per clock toward the VGA adapter.
module block_drawer #(
    parameter int             BLOCK_W   = 20,
    parameter int             BLOCK_H   = 4,
    parameter int             SCREEN_W  = 160,
    parameter int             SCREEN_H  = 120,
    parameter logic [2:0]     BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [7:0] prev_x,
    input  logic [2:0] colour,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    localparam logic [5:0] CX_LAST = 6'(BLOCK_W - 1);
    localparam logic [3:0] CY_LAST = 4'(BLOCK_H - 1);
    localparam logic [8:0] SCR_W   = 9'(SCREEN_W);
    localparam logic [7:0] SCR_H   = 8'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

    state_t     state, state_n;
    logic [5:0] cx, cx_n;
    logic [3:0] cy, cy_n;
    logic [7:0] lat_x, lat_x_n, lat_px, lat_px_n;
    logic [6:0] lat_y, lat_y_n;
    logic [2:0] lat_col, lat_col_n;

    logic [7:0] base_p0;
    logic [8:0] col_sum_p0;
    logic [7:0] row_sum_p0;
    logic [2:0] col_p0;
    logic       vld_p0;

    // Pixels past the right or bottom edge are dropped rather than wrapped.
    function automatic logic on_screen(input logic [8:0] cs, input logic [7:0] rs);
        return (cs < SCR_W) && (rs < SCR_H);
    endfunction

    always_comb begin
        state_n   = state;
        cx_n      = cx;
        cy_n      = cy;
        lat_x_n   = lat_x;
        lat_px_n  = lat_px;
        lat_y_n   = lat_y;
        lat_col_n = lat_col;
        case (state)
            IDLE: begin
                if (sync) begin
                    lat_x_n   = x;
                    lat_px_n  = prev_x;
                    lat_y_n   = y;
                    lat_col_n = colour;
                    cx_n      = '0;
                    cy_n      = '0;
                    state_n   = (prev_x != x) ? ERASE : DRAW;
                end
            end
            ERASE, DRAW: begin
                if (cx == CX_LAST && cy == CY_LAST) begin
                    cx_n    = '0;
                    cy_n    = '0;
                    state_n = (state == ERASE) ? DRAW : DONE;
                end else if (cx == CX_LAST) begin
                    cx_n = '0;
                    cy_n = cy + 4'd1;
                end else begin
                    cx_n = cx + 6'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stage p0: address and colour of the pixel that will be on the outputs next cycle
    always_comb begin
        base_p0    = (state_n == ERASE) ? lat_px_n : lat_x_n;
        col_p0     = (state_n == ERASE) ? BG_COLOUR : lat_col_n;
        col_sum_p0 = {1'b0, base_p0} + {3'b000, cx_n};
        row_sum_p0 = {1'b0, lat_y_n} + {4'b0000, cy_n};
        vld_p0     = (state_n == ERASE) || (state_n == DRAW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cx    <= '0;
            cy    <= '0;
        end else begin
            state <= state_n;
            cx    <= cx_n;
            cy    <= cy_n;
        end
    end

    always_ff @(posedge clk) begin
        lat_x   <= lat_x_n;
        lat_px  <= lat_px_n;
        lat_y   <= lat_y_n;
        lat_col <= lat_col_n;
    end

    // Stage p1: registered pixel-write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (vld_p0) begin
                vga_x      <= col_sum_p0[7:0];
                vga_y      <= row_sum_p0[6:0];
                vga_colour <= col_p0;
            end
            plot <= vld_p0 && on_screen(col_sum_p0, row_sum_p0);
            busy <= vld_p0;
            done <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_block_drawer.sv
// Directed bench for block_drawer: frame timing, pixel order, clipping,
// ignored re-sync and mid-frame reset.
module tb_block_drawer;

    localparam int W = 20;
    localparam int H = 4;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [7:0] prev_x = '0;
    logic [2:0] colour = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    int total = 0;
    int bad = 0;

    block_drawer dut (
        .clk        (clk),
        .reset      (reset),
        .sync       (sync),
        .x          (x),
        .y          (y),
        .prev_x     (prev_x),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Runs one frame; samples are taken 1 time unit after each rising edge,
    // and sample k is the k-th cycle after the edge that accepted sync.
    task automatic run_frame(input string tag, input logic [7:0] px, input logic [7:0] nx,
                             input logic [6:0] ny, input logic [2:0] col,
                             input int exp_plots, input int exp_done, input bit resync);
        int errs = 0;
        int plots = 0;
        int done_at = -1;
        int after = 0;
        bit erase = (px != nx);
        int active = erase ? 2 * N : N;
        int idx, base, cs, rs, ecol;
        bit eplot;
        @(posedge clk); #1;
        prev_x = px; x = nx; y = ny; colour = col; sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        for (int k = 1; k <= 400 && done_at < 0; k++) begin
            if (resync && k == 5) begin
                sync = 1'b1; x = nx + 8'd3; prev_x = px + 8'd7; y = ny - 7'd2; colour = ~col;
            end
            if (resync && k == 6) sync = 1'b0;
            if (k <= active) begin
                if (erase && k <= N) begin
                    idx = k - 1; base = int'(px); ecol = 0;
                end else begin
                    idx = k - 1 - (erase ? N : 0); base = int'(nx); ecol = int'(col);
                end
                cs = base + idx % W;
                rs = int'(ny) + idx / W;
                eplot = (cs < 160) && (rs < 120);
                if (int'(vga_x) != cs % 256 || int'(vga_y) != rs % 128 ||
                    int'(vga_colour) != ecol || plot != eplot || busy != 1'b1 || done != 1'b0) begin
                    if (errs < 4)
                        $display("  %s cycle %0d: x=%0d y=%0d c=%0d plot=%0d want x=%0d y=%0d c=%0d plot=%0d",
                                 tag, k, vga_x, vga_y, vga_colour, plot, cs % 256, rs % 128, ecol, eplot);
                    errs++;
                end
            end else if (k == active + 1) begin
                if (done != 1'b1 || busy != 1'b0 || plot != 1'b0) errs++;
            end
            if (plot) plots++;
            if (done) done_at = k;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 8; k++) begin
            if (plot || busy || done) after++;
            @(posedge clk); #1;
        end
        check({tag, "_pixels"}, errs, 0);
        check({tag, "_plots"}, plots, exp_plots);
        check({tag, "_done_cycle"}, done_at, exp_done);
        check({tag, "_idle_after"}, after, 0);
    endtask

    initial begin : stim
        int errs;
        // Reset held: sync must not start anything
        errs = 0;
        repeat (2) @(posedge clk);
        #1;
        prev_x = 8'd10; x = 8'd14; y = 7'd100; colour = 3'b100; sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (plot || busy || done || vga_x != 0 || vga_y != 0 || vga_colour != 0) errs++;
            @(posedge clk); #1;
        end
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_held_cycles", errs, 0);
        reset = 1'b0;

        run_frame("erase_draw", 8'd10, 8'd14, 7'd100, 3'b100, 160, 161, 1'b0);
        run_frame("no_erase", 8'd50, 8'd50, 7'd30, 3'b011, 80, 81, 1'b0);
        run_frame("clip", 8'd150, 8'd150, 7'd118, 3'b111, 20, 81, 1'b0);
        run_frame("resync", 8'd20, 8'd30, 7'd10, 3'b010, 160, 161, 1'b1);

        // Reset 40 cycles into DRAW aborts at once
        @(posedge clk); #1;
        prev_x = 8'd50; x = 8'd50; y = 7'd20; colour = 3'b010; sync = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0;
        repeat (39) begin
            @(posedge clk); #1;
        end
        check("mid_plot_before", int'(plot), 1);
        check("mid_busy_before", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("mid_plot_async", int'(plot), 0);
        check("mid_busy_async", int'(busy), 0);
        check("mid_done_async", int'(done), 0);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (plot || busy || done) errs++;
        end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (plot || busy || done) errs++;
        end
        check("mid_after_reset", errs, 0);
        run_frame("fresh", 8'd10, 8'd14, 7'd100, 3'b100, 160, 161, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
